// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read channel (AR/R) between the I-cache refill port and
// the D-cache refill/uncached-load port, one outstanding burst at a time.
// Latency: ack is combinational in the grant cycle and arvalid rises on the
// next cycle. Backpressure: arready stalls the burst in ADDR, and rready
// follows the granted requester's rready.
//
// Ports:
//   aclk, aresetn                 clock, synchronous active-low reset
//   {i,d}_req/addr/len/size       held read-burst request from each cache port
//   {i,d}_ack                     one-cycle pulse when that request is latched
//   {i,d}_rvalid/rready/rlast     per-requester view of the R channel
//   r_data, r_resp                rdata/rresp broadcast to both requesters
//   ar*, arready                  AXI3 read-address channel toward the slave
//   rid/rdata/rresp/rlast/rvalid  AXI3 read-data channel from the slave
//   rready                        AXI3 read-data ready toward the slave
//   err_rlast                     sticky flag: rlast disagreed with latched len
module axi_read_arbiter #(
  parameter logic [3:0] I_ARID       = 4'd0,
  parameter logic [3:0] D_ARID       = 4'd1,
  parameter int         STARVE_LIMIT = 4
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_len,
  input  logic [2:0]  i_size,
  output logic        i_ack,
  output logic        i_rvalid,
  input  logic        i_rready,
  output logic        i_rlast,

  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_len,
  input  logic [2:0]  d_size,
  output logic        d_ack,
  output logic        d_rvalid,
  input  logic        d_rready,
  output logic        d_rlast,

  output logic [31:0] r_data,
  output logic [1:0]  r_resp,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic        err_rlast
);

  // Counter just wide enough to hold STARVE_LIMIT itself.
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched burst owner and AR payload; stable from grant until the next grant.
  logic          gnt_d;
  logic [3:0]    ar_id;
  logic [31:0]   ar_addr;
  logic [3:0]    ar_len;
  logic [2:0]    ar_size;

  logic [3:0]    beat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          err_q;

  logic          starved;
  logic          pick_i;
  logic          pick_d;
  logic          beat;

  // rid is ignored: with a single outstanding burst the owner is already known.
  logic          rid_unused;
  assign rid_unused = ^rid;

  // D normally wins a tie; once I has watched STARVE_LIMIT consecutive D
  // grants go by, I takes the next tie.
  assign starved = (starve_cnt == STARVE_MAX);
  assign pick_i  = i_req & (~d_req | starved);
  assign pick_d  = d_req & ~pick_i;
  assign beat    = rvalid & rready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    case (state)
      S_IDLE: begin
        // Acks are masked during reset so a held request never sees a
        // spurious pulse while the block is being cleared.
        if (aresetn) begin
          i_ack = pick_i;
          d_ack = pick_d;
          if (pick_i || pick_d) begin
            state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rready   = gnt_d ? d_rready : i_rready;
        i_rvalid = rvalid & ~gnt_d;
        d_rvalid = rvalid &  gnt_d;
        i_rlast  = rvalid & rlast & ~gnt_d;
        d_rlast  = rvalid & rlast &  gnt_d;
        if (beat && rlast) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      gnt_d      <= 1'b0;
      ar_id      <= 4'd0;
      ar_addr    <= 32'd0;
      ar_len     <= 4'd0;
      ar_size    <= 3'd0;
      beat_cnt   <= 4'd0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        beat_cnt <= 4'd0;
        if (pick_i) begin
          gnt_d      <= 1'b0;
          ar_id      <= I_ARID;
          ar_addr    <= i_addr;
          ar_len     <= i_len;
          ar_size    <= i_size;
          starve_cnt <= '0;
        end else if (pick_d) begin
          gnt_d   <= 1'b1;
          ar_id   <= D_ARID;
          ar_addr <= d_addr;
          ar_len  <= d_len;
          ar_size <= d_size;
          if (!i_req) begin
            starve_cnt <= '0;
          end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
          end
        end else begin
          // No requester at all, so I is certainly not waiting.
          starve_cnt <= '0;
        end
      end

      if ((state == S_DATA) && beat) begin
        if (rlast) begin
          // Short burst: slave ended before the requested beat count.
          if (beat_cnt != ar_len) begin
            err_q <= 1'b1;
          end
          beat_cnt <= 4'd0;
        end else begin
          // Long burst: expected last beat came without rlast; keep draining.
          if (beat_cnt == ar_len) begin
            err_q <= 1'b1;
          end
          beat_cnt <= beat_cnt + 4'd1;
        end
      end
    end
  end

  assign arid      = ar_id;
  assign araddr    = ar_addr;
  assign arlen     = ar_len;
  assign arsize    = ar_size;
  assign arburst   = 2'b01;
  assign arlock    = 2'b00;
  assign arcache   = 4'b0000;
  assign arprot    = 3'b000;

  assign r_data    = rdata;
  assign r_resp    = rresp;
  assign err_rlast = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter: table-driven bursts, hand-written corner
// sequences (starvation, AR stall, rlast errors, mid-burst reset) and random
// traffic checked against a rule-level grant model.
module tb_axi_read_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam logic [3:0] I_ID = 4'd0;
  localparam logic [3:0] D_ID = 4'd1;

  logic        aclk, aresetn;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr;
  logic [3:0]  i_len, d_len;
  logic [2:0]  i_size, d_size;
  logic        i_ack, d_ack, i_rvalid, d_rvalid, i_rready, d_rready, i_rlast, d_rlast;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready, err_rlast;

  int n_chk = 0;
  int n_fail = 0;

  axi_read_arbiter #(.I_ARID(I_ID), .D_ARID(D_ID), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size), .i_ack(i_ack),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rlast(i_rlast),
    .d_req(d_req), .d_addr(d_addr), .d_len(d_len), .d_size(d_size), .d_ack(d_ack),
    .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rlast(d_rlast),
    .r_data(r_data), .r_resp(r_resp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_rlast(err_rlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required end of test first");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_i(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
    i_req = 1'b1; i_addr = a; i_len = l; i_size = s;
  endtask

  task automatic set_d(input logic [31:0] a, input logic [3:0] l, input logic [2:0] s);
    d_req = 1'b1; d_addr = a; d_len = l; d_size = s;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    i_req = 1'b1; d_req = 1'b1; rvalid = 1'b1; arready = 1'b0;
    tick();
    tick();
    @(negedge aclk);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_err_rlast", 32'(err_rlast), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arlen", 32'(arlen), 32'd0);
    i_req = 1'b0; d_req = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    aresetn = 1'b1;
    tick();
  endtask

  // Entered one drive slot after a clock edge with requests already driven
  // and the DUT idle; returns in the drive slot after the burst's last beat.
  task automatic run_burst(input bit exp_d, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input int ar_wait, input int rlast_at,
                           input bit gaps);
    bit rr;
    int tries;
    int ng;
    @(negedge aclk);
    chk("grant_i_ack", 32'(i_ack), 32'(!exp_d));
    chk("grant_d_ack", 32'(d_ack), 32'(exp_d));
    chk("grant_arvalid", 32'(arvalid), 32'd0);
    tick();
    if (exp_d) d_req = 1'b0; else i_req = 1'b0;
    for (int w = 0; w < ar_wait; w++) begin
      @(negedge aclk);
      chk("stall_arvalid", 32'(arvalid), 32'd1);
      chk("stall_araddr", araddr, addr);
      chk("stall_rready", 32'(rready), 32'd0);
      chk("stall_acks", 32'({i_ack, d_ack}), 32'd0);
      tick();
    end
    arready = 1'b1;
    @(negedge aclk);
    chk("ar_arvalid", 32'(arvalid), 32'd1);
    chk("ar_araddr", araddr, addr);
    chk("ar_arid", 32'(arid), 32'(exp_d ? D_ID : I_ID));
    chk("ar_arlen", 32'(arlen), 32'(len));
    chk("ar_arsize", 32'(arsize), 32'(size));
    chk("ar_arburst", 32'(arburst), 32'd1);
    chk("ar_fixed", 32'({arlock, arcache, arprot}), 32'd0);
    chk("ar_rready", 32'(rready), 32'd0);
    tick();
    arready = 1'b0;
    for (int k = 0; k <= rlast_at; k++) begin
      ng = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ng; g++) begin
        rvalid = 1'b0;
        rr = 1'($urandom_range(0, 1));
        if (exp_d) begin d_rready = rr; i_rready = 1'($urandom); end
        else begin i_rready = rr; d_rready = 1'($urandom); end
        @(negedge aclk);
        chk("gap_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("gap_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("gap_rready", 32'(rready), 32'(rr));
        tick();
      end
      rvalid = 1'b1;
      rdata  = $urandom;
      rresp  = 2'($urandom_range(0, 3));
      rid    = 4'($urandom);
      rlast  = (k == rlast_at);
      tries  = 0;
      do begin
        rr = gaps ? ((tries >= 3) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b1;
        if (exp_d) begin d_rready = rr; i_rready = 1'($urandom); end
        else begin i_rready = rr; d_rready = 1'($urandom); end
        @(negedge aclk);
        chk("beat_rvalid_sel", 32'(exp_d ? d_rvalid : i_rvalid), 32'd1);
        chk("beat_rvalid_other", 32'(exp_d ? i_rvalid : d_rvalid), 32'd0);
        chk("beat_rlast_sel", 32'(exp_d ? d_rlast : i_rlast), 32'(k == rlast_at));
        chk("beat_rlast_other", 32'(exp_d ? i_rlast : d_rlast), 32'd0);
        chk("beat_rready", 32'(rready), 32'(rr));
        chk("beat_r_data", r_data, rdata);
        chk("beat_r_resp", 32'(r_resp), 32'(rresp));
        chk("beat_arvalid", 32'(arvalid), 32'd0);
        tick();
        tries++;
      end while (!rr);
    end
    rvalid = 1'b0; rlast = 1'b0; i_rready = 1'b0; d_rready = 1'b0;
  endtask

  typedef struct {
    bit          i_rq;
    bit          d_rq;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    int          ar_wait;
    bit          first_d;
  } vec_t;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [3:0]  l;
    logic [2:0]  s;
  } pend_t;

  vec_t  tbl[6];
  pend_t pi, pd;
  int    starve;
  bit    wd;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h1FC0_0000, 4'd7,  3'd2, 0,  1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h8000_1000, 4'd3,  3'd2, 2,  1'b1};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0040, 4'd0,  3'd2, 0,  1'b1};
    tbl[3] = '{1'b1, 1'b1, 32'hFFFF_FC00, 4'd15, 3'd1, 1,  1'b1};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0004, 4'd0,  3'd0, 3,  1'b0};
    tbl[5] = '{1'b0, 1'b1, 32'h1234_5670, 4'd1,  3'd2, 10, 1'b1};

    aresetn = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    i_addr = '0; d_addr = '0; i_len = '0; d_len = '0; i_size = '0; d_size = '0;
    i_rready = 1'b0; d_rready = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

    do_reset();

    // Table: single and simultaneous requests, D then I on a tie.
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].i_rq) set_i(tbl[r].addr, tbl[r].len, tbl[r].size);
      if (tbl[r].d_rq) set_d(tbl[r].addr + 32'h100, tbl[r].len, tbl[r].size);
      run_burst(tbl[r].first_d, tbl[r].first_d ? tbl[r].addr + 32'h100 : tbl[r].addr,
                tbl[r].len, tbl[r].size, tbl[r].ar_wait, int'(tbl[r].len), 1'b0);
      if (tbl[r].i_rq && tbl[r].d_rq)
        run_burst(!tbl[r].first_d, tbl[r].first_d ? tbl[r].addr : tbl[r].addr + 32'h100,
                  tbl[r].len, tbl[r].size, 0, int'(tbl[r].len), 1'b1);
    end
    @(negedge aclk);
    chk("table_err_rlast", 32'(err_rlast), 32'd0);
    tick();

    // Starvation: D re-requests continuously; I gets in after four D grants,
    // and the second round shows the count restarted from zero.
    for (int rd = 0; rd < 2; rd++) begin
      set_i(32'h0000_2000, 4'd1, 3'd2);
      for (int k = 0; k < 5; k++) begin
        set_d(32'h0000_3000 + 32'(k * 16), 4'd1, 3'd2);
        run_burst(k < 4, (k < 4) ? d_addr : i_addr, 4'd1, 3'd2, 0, 1, 1'b0);
      end
    end
    d_req = 1'b0;

    // Short burst: rlast on beat 2 of a 4-beat burst sets the sticky error.
    do_reset();
    set_i(32'h0000_4000, 4'd3, 3'd2);
    run_burst(1'b0, 32'h0000_4000, 4'd3, 3'd2, 0, 2, 1'b0);
    @(negedge aclk);
    chk("short_err_rlast", 32'(err_rlast), 32'd1);
    tick();
    set_d(32'h0000_5000, 4'd2, 3'd2);
    run_burst(1'b1, 32'h0000_5000, 4'd2, 3'd2, 1, 2, 1'b1);
    @(negedge aclk);
    chk("short_err_sticky", 32'(err_rlast), 32'd1);
    tick();

    // Long burst: no rlast at the expected last beat; DUT keeps draining.
    do_reset();
    set_d(32'h0000_6000, 4'd1, 3'd2);
    run_burst(1'b1, 32'h0000_6000, 4'd1, 3'd2, 0, 3, 1'b0);
    @(negedge aclk);
    chk("long_err_rlast", 32'(err_rlast), 32'd1);
    tick();

    // Reset during beat 2 of an 8-beat burst aborts without draining.
    do_reset();
    set_i(32'h0000_7000, 4'd7, 3'd2);
    @(negedge aclk);
    chk("abort_i_ack", 32'(i_ack), 32'd1);
    tick();
    i_req = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rlast = 1'b0; i_rready = 1'b1; rdata = $urandom;
      tick();
    end
    aresetn = 1'b0;
    @(negedge aclk);
    chk("abort_pre_edge_rvalid", 32'(i_rvalid), 32'd1);
    tick();
    @(negedge aclk);
    chk("abort_arvalid", 32'(arvalid), 32'd0);
    chk("abort_rready", 32'(rready), 32'd0);
    chk("abort_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("abort_err_rlast", 32'(err_rlast), 32'd0);
    aresetn = 1'b1; rvalid = 1'b0; i_rready = 1'b0;
    tick();
    @(negedge aclk);
    chk("abort_idle_arvalid", 32'(arvalid), 32'd0);
    tick();
    set_d(32'h0000_8000, 4'd0, 3'd2);
    run_burst(1'b1, 32'h0000_8000, 4'd0, 3'd2, 0, 0, 1'b0);

    // Random traffic against the grant-rule model.
    do_reset();
    pi = '{1'b0, 32'd0, 4'd0, 3'd0};
    pd = '{1'b0, 32'd0, 4'd0, 3'd0};
    starve = 0;
    for (int n = 0; n < 150; n++) begin
      if (!pi.v && ($urandom_range(0, 1) == 1))
        pi = '{1'b1, $urandom, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2))};
      if (!pd.v && ($urandom_range(0, 9) < 8))
        pd = '{1'b1, $urandom, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2))};
      if (!pi.v && !pd.v)
        pi = '{1'b1, $urandom, 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2))};
      if (pi.v) set_i(pi.a, pi.l, pi.s);
      if (pd.v) set_d(pd.a, pd.l, pd.s);
      wd = pd.v && !(pi.v && (starve == STARVE_LIMIT));
      if (wd && pi.v) starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
      else starve = 0;
      if (wd) begin
        run_burst(1'b1, pd.a, pd.l, pd.s, int'($urandom_range(0, 3)), int'(pd.l), 1'b1);
        pd.v = 1'b0;
      end else begin
        run_burst(1'b0, pi.a, pi.l, pi.s, int'($urandom_range(0, 3)), int'(pi.l), 1'b1);
        pi.v = 1'b0;
      end
    end
    @(negedge aclk);
    chk("random_err_rlast", 32'(err_rlast), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
